// File: rtl/field_canon_buf_if.sv
// Producer/consumer bundle for the canonicalising result buffer.
// The master side drives results and pops; the slave side is the buffer.
interface field_canon_buf_if #(
  parameter int WIDTH = 255,
  parameter int DEPTH = 4
);
  logic                     in_valid;
  logic [WIDTH-1:0]         in_data;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH-1:0]         out_data;
  logic [$clog2(DEPTH):0]   count;
  logic                     overflow;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  out_valid, out_data, count, overflow
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output out_valid, out_data, count, overflow
  );
endinterface

// File: rtl/field_canon_buf.sv
// Maps [0, 2^255) multiplier results into [0, 2^255-19); 2 cycles in_valid -> out_valid.
// Backpressure via out_ready only: input cannot stall, so a full FIFO drops and sets sticky overflow.
module field_canon_buf #(
  parameter int WIDTH = 255,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  field_canon_buf_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  // p = 2^WIDTH - 19, held one bit wider so the compare/subtract cannot wrap
  localparam logic [WIDTH:0] P_EXT = {1'b0, {WIDTH{1'b1}}} - (WIDTH+1)'(18);

  logic [WIDTH:0]   in_ext;
  logic [WIDTH:0]   in_sub;
  logic [WIDTH-1:0] canon;

  logic             s1_valid;
  logic [WIDTH-1:0] s1_data;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             overflow;

  logic             full;
  logic             pop;
  logic             push;

  always_comb begin
    in_ext = {1'b0, bus.in_data};
    in_sub = in_ext - P_EXT;
    canon  = (in_ext >= P_EXT) ? in_sub[WIDTH-1:0] : bus.in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else if (bus.flush) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_data <= canon;
      end
    end
  end

  assign full = (count == CW'(DEPTH));
  assign pop  = bus.out_valid & bus.out_ready;
  // A full FIFO still accepts when the head leaves on the same edge
  assign push = s1_valid & ~bus.flush & (~full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= s1_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
      if (s1_valid && full && !pop) begin
        overflow <= 1'b1;
      end
    end
  end

  assign bus.out_valid = (count != '0);
  assign bus.out_data  = mem[rd_ptr];
  assign bus.count     = count;
  assign bus.overflow  = overflow;
endmodule

// File: tb/tb_field_canon_buf.sv
// Directed checks of canonicalisation, FIFO ordering, overflow, flush and async reset.
module tb_field_canon_buf;
  localparam int WIDTH = 255;
  localparam int DEPTH = 4;
  localparam logic [WIDTH-1:0] P = {WIDTH{1'b1}} - WIDTH'(18);

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  field_canon_buf_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  field_canon_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single result through an otherwise idle buffer; expects the exact 2-edge latency.
  task automatic send_check(input string tag, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] exp);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    check({tag, "_lat1"}, 256'(bus.out_valid), 256'(1'b0));
    step();
    check({tag, "_vld"}, 256'(bus.out_valid), 256'(1'b1));
    check({tag, "_dat"}, 256'(bus.out_data), 256'(exp));
    step();
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    check("rst_vld",  256'(bus.out_valid), 256'(1'b0));
    check("rst_cnt",  256'(bus.count),     256'(0));
    check("rst_ovf",  256'(bus.overflow),  256'(1'b0));
    check("rst_dat",  256'(bus.out_data),  256'(0));
    step();
    rst = 1'b0;
    step();

    // Canonicalisation corner values
    bus.out_ready = 1'b1;
    send_check("mul99",  WIDTH'(99),                    WIDTH'(99));
    send_check("p_plus5", P + WIDTH'(5),                WIDTH'(5));
    send_check("allones", {WIDTH{1'b1}},                WIDTH'(18));
    send_check("p_eq",   P,                             WIDTH'(0));
    send_check("p_m1",   P - WIDTH'(1),                 P - WIDTH'(1));
    check("drain_cnt", 256'(bus.count), 256'(0));

    // Six back-to-back results into a stalled FIFO: 5 and 6 are dropped
    bus.out_ready = 1'b0;
    for (int i = 1; i <= DEPTH + 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    check("ovf_cnt", 256'(bus.count),    256'(4));
    check("ovf_flag", 256'(bus.overflow), 256'(1'b1));
    bus.out_ready = 1'b1;
    for (int i = 1; i <= DEPTH; i++) begin
      check($sformatf("ovf_vld%0d", i), 256'(bus.out_valid), 256'(1'b1));
      check($sformatf("ovf_dat%0d", i), 256'(bus.out_data),  256'(i));
      step();
    end
    check("ovf_empty", 256'(bus.out_valid), 256'(1'b0));
    check("ovf_sticky", 256'(bus.overflow), 256'(1'b1));

    // Flush with concurrent input and pop clears everything, including overflow
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = WIDTH'(101);
    step();
    bus.in_data   = WIDTH'(102);
    step();
    bus.in_data   = WIDTH'(777);
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    check("fl_cnt", 256'(bus.count),     256'(0));
    check("fl_vld", 256'(bus.out_valid), 256'(1'b0));
    check("fl_ovf", 256'(bus.overflow),  256'(1'b0));
    step();
    check("fl_noleak", 256'(bus.out_valid), 256'(1'b0));
    send_check("fl_next", WIDTH'(42), WIDTH'(42));

    // Full FIFO with simultaneous push and pop: count holds, nothing dropped
    bus.out_ready = 1'b0;
    for (int i = 11; i <= 15; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(i);
      step();
    end
    check("ss_full", 256'(bus.count), 256'(4));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_data = WIDTH'(16 + i);
      check($sformatf("ss_dat%0d", i), 256'(bus.out_data), 256'(11 + i));
      step();
      check($sformatf("ss_cnt%0d", i), 256'(bus.count), 256'(4));
    end
    check("ss_ovf", 256'(bus.overflow), 256'(1'b0));
    bus.in_valid = 1'b0;
    bus.flush    = 1'b1;
    step();
    bus.flush = 1'b0;

    // Async reset with three entries queued and stage 1 occupied
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = WIDTH'(200 + i);
      step();
    end
    bus.in_valid = 1'b0;
    check("ar_pre_cnt", 256'(bus.count), 256'(3));
    #1;
    rst = 1'b1;
    #1;
    check("ar_vld", 256'(bus.out_valid), 256'(1'b0));
    check("ar_cnt", 256'(bus.count),     256'(0));
    #1;
    rst = 1'b0;
    step();
    check("ar_s1_gone", 256'(bus.out_valid), 256'(1'b0));
    bus.out_ready = 1'b1;
    send_check("ar_next", WIDTH'(55), WIDTH'(55));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
